// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one single-port, fixed-latency memory between the core's
// instruction-fetch port and its load/store port. Only one transaction is in
// flight at a time. Data normally wins arbitration. A streak counter hands the
// memory to a waiting fetch after MAX_DSTREAK back-to-back data grants, so
// fetch is never starved.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   if_req/if_addr      fetch request in, held until if_gnt
//   if_gnt              fetch grant pulse
//   if_rvalid/if_rdata  fetch response (one-cycle pulse, data held afterwards)
//   d_req/d_we/d_addr/d_wdata/d_be   data request in, held until d_gnt
//   d_gnt               data grant pulse
//   d_rvalid/d_rdata    load data or store completion (data held afterwards)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be   memory command, grant cycle only
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_en
//   busy                high while a transaction is outstanding
//
// state  | meaning
// S_IDLE | no transaction outstanding; a request is granted in this cycle
// S_WAIT | waiting MEM_LAT cycles for the memory to return read data

module riscv_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 1,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  // Down-counter holds the WAIT cycles still to go before the capture cycle.
  localparam logic [1:0] LAT_LOAD   = 2'(MEM_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_lat;
  logic [3:0]        r_streak;
  logic              r_own_f;
  logic              r_own_st;
  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_pick_f;
  logic              w_pick_d;
  logic              w_capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grants are combinational and are also forced low while reset is held,
  // since the request inputs may already be high during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_pick_f    = 1'b0;
    w_pick_d    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reset) begin
          w_pick_f = if_req && (!d_req || (r_streak == STREAK_MAX));
          w_pick_d = d_req && !w_pick_f;
        end
        if (w_pick_f || w_pick_d) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_lat == 2'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat       <= 2'd0;
      r_streak    <= 4'd0;
      r_own_f     <= 1'b0;
      r_own_st    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;

      if (w_pick_f || w_pick_d) begin
        r_lat    <= LAT_LOAD;
        r_own_f  <= w_pick_f;
        r_own_st <= w_pick_d && d_we;
      end else if ((r_state == S_WAIT) && (r_lat != 2'd0)) begin
        r_lat <= r_lat - 2'd1;
      end

      if (w_capture) begin
        if (r_own_f) begin
          r_if_rdata  <= mem_rdata;
          r_if_rvalid <= 1'b1;
        end else begin
          r_d_rvalid <= 1'b1;
          if (!r_own_st) r_d_rdata <= mem_rdata;
        end
      end

      // Streak only counts data grants that made a fetch wait.
      if (w_pick_f) begin
        r_streak <= 4'd0;
      end else if (w_pick_d) begin
        if (!if_req)                      r_streak <= 4'd0;
        else if (r_streak < STREAK_MAX)   r_streak <= r_streak + 4'd1;
      end
    end
  end

  assign if_gnt    = w_pick_f;
  assign d_gnt     = w_pick_d;
  assign mem_en    = w_pick_f || w_pick_d;
  assign mem_we    = w_pick_d && d_we;
  assign mem_addr  = w_pick_d ? d_addr : (w_pick_f ? if_addr : '0);
  assign mem_wdata = w_pick_d ? d_wdata : '0;
  assign mem_be    = w_pick_d ? d_be : {BE_W{1'b0}};
  assign busy      = (r_state == S_WAIT);
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: one instance with MEM_LAT=1 (index 0) and one
// with MEM_LAT=3 (index 1), both MAX_DSTREAK=4. A transaction-level model
// (next-free cycle, response cycle, streak count) predicts every output each
// cycle; directed steps then random traffic.
module tb_riscv_mem_arbiter;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0]       if_req, d_req, d_we;
  logic [1:0][31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0][3:0]  d_be;
  wire  [1:0]       if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  wire  [1:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  wire  [1:0][3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int t0;

  int          free_at[2], resp_cyc[2], mret_cyc[2], streak[2];
  bit          resp_f[2], resp_st[2], m_fg[2], m_dg[2];
  logic [31:0] resp_data[2], mret_addr[2], exp_if_rd[2], exp_d_rd[2];

  int          fg_c[2], dg_c[2], frv_c[2], drv_c[2], busy_n[2];
  logic [31:0] frv_data[2], fg_addr[2], st_wd[2];
  logic        fg_we[2], st_we[2];
  logic [3:0]  st_be[2];
  string       order[2];

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DSTREAK(MAXS)) u_dut_l1 (
    .clk(clk), .reset(reset_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_be(d_be[0]), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]));

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_DSTREAK(MAXS)) u_dut_l3 (
    .clk(clk), .reset(reset_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_be(d_be[1]), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]));

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Memory contents: fixed word at 0x10, hash elsewhere.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A00093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat%0d cycle %0d: observed %h expected %h", tag, lat(k), cyc_n, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  task automatic reset_model(input int k);
    free_at[k]   = cyc_n + 1;
    resp_cyc[k]  = -1;
    mret_cyc[k]  = -1;
    streak[k]    = 0;
    exp_if_rd[k] = '0;
    exp_d_rd[k]  = '0;
  endtask

  task automatic clr_log(input int k);
    fg_c[k] = -1; dg_c[k] = -1; frv_c[k] = -1; drv_c[k] = -1; busy_n[k] = 0;
    order[k] = "";
  endtask

  task automatic check(input int k);
    logic [31:0] e_fg, e_dg, e_en, e_we, e_busy, e_frv, e_drv, e_addr, e_wd, e_be;
    bit idle;
    e_fg = 0; e_dg = 0; e_en = 0; e_we = 0; e_busy = 0; e_frv = 0; e_drv = 0;
    e_addr = 0; e_wd = 0; e_be = 0;
    m_fg[k] = 1'b0;
    m_dg[k] = 1'b0;
    if (!reset_n) begin
      reset_model(k);
      idle = 1'b1;
    end else begin
      idle   = (cyc_n >= free_at[k]);
      e_busy = idle ? 32'd0 : 32'd1;
      if (cyc_n == resp_cyc[k]) begin
        if (resp_f[k]) begin
          e_frv = 1; exp_if_rd[k] = resp_data[k];
        end else begin
          e_drv = 1;
          if (!resp_st[k]) exp_d_rd[k] = resp_data[k];
        end
      end
      if (idle) begin
        m_fg[k] = if_req[k] && (!d_req[k] || streak[k] == MAXS);
        m_dg[k] = d_req[k] && !m_fg[k];
        if (m_fg[k]) begin
          e_fg = 1; e_en = 1; e_addr = if_addr[k];
        end
        if (m_dg[k]) begin
          e_dg = 1; e_en = 1; e_we = {31'b0, d_we[k]}; e_addr = d_addr[k];
          e_wd = d_wdata[k]; e_be = {28'b0, d_be[k]};
        end
      end
    end
    chk("if_gnt",    k, 32'(if_gnt[k]),    e_fg);
    chk("d_gnt",     k, 32'(d_gnt[k]),     e_dg);
    chk("mem_en",    k, 32'(mem_en[k]),    e_en);
    chk("busy",      k, 32'(busy[k]),      e_busy);
    chk("if_rvalid", k, 32'(if_rvalid[k]), e_frv);
    chk("d_rvalid",  k, 32'(d_rvalid[k]),  e_drv);
    chk("if_rdata",  k, if_rdata[k],       exp_if_rd[k]);
    chk("d_rdata",   k, d_rdata[k],        exp_d_rd[k]);
    if (idle) begin
      chk("mem_we", k, 32'(mem_we[k]), e_we);
      chk("mem_be", k, 32'(mem_be[k]), e_be);
    end
    if (e_en != 0) chk("mem_addr", k, mem_addr[k], e_addr);
    if (m_dg[k])   chk("mem_wdata", k, mem_wdata[k], e_wd);

    if (m_fg[k] || m_dg[k]) begin
      free_at[k]   = cyc_n + lat(k) + 1;
      resp_cyc[k]  = free_at[k];
      resp_f[k]    = m_fg[k];
      resp_st[k]   = m_dg[k] && d_we[k];
      resp_data[k] = memf(e_addr);
      mret_cyc[k]  = cyc_n + lat(k);
      mret_addr[k] = e_addr;
      if (m_fg[k] || !if_req[k]) streak[k] = 0;
      else if (streak[k] < MAXS) streak[k] = streak[k] + 1;
    end

    if (if_gnt[k]) begin
      fg_c[k] = cyc_n; fg_addr[k] = mem_addr[k]; fg_we[k] = mem_we[k];
      order[k] = {order[k], "F"};
    end
    if (d_gnt[k]) begin
      dg_c[k] = cyc_n; st_we[k] = mem_we[k]; st_be[k] = mem_be[k]; st_wd[k] = mem_wdata[k];
      order[k] = {order[k], "D"};
    end
    if (if_rvalid[k] && frv_c[k] < 0) begin
      frv_c[k] = cyc_n; frv_data[k] = if_rdata[k];
    end
    if (d_rvalid[k] && drv_c[k] < 0) drv_c[k] = cyc_n;
    if (busy[k]) busy_n[k]++;
  endtask

  task automatic cyc();
    @(negedge clk);
    check(0);
    check(1);
    @(posedge clk);
    #1;
    cyc_n++;
    for (int k = 0; k < 2; k++) begin
      if (m_fg[k]) if_req[k] = 1'b0;
      if (m_dg[k]) d_req[k] = 1'b0;
      mem_rdata[k] = (cyc_n == mret_cyc[k]) ? memf(mret_addr[k]) : $urandom();
    end
  endtask

  task automatic rnd(input int k);
    if (!if_req[k]) begin
      if ($urandom_range(2) == 0) begin
        if_req[k] = 1'b1; if_addr[k] = $urandom() & 32'hFFFF_FFFC;
      end
    end else if ($urandom_range(15) == 0) begin
      if_req[k] = 1'b0;
    end
    if (!d_req[k]) begin
      if ($urandom_range(2) == 0) begin
        d_req[k] = 1'b1; d_we[k] = 1'($urandom_range(1));
        d_addr[k] = $urandom() & 32'hFFFF_FFFC; d_wdata[k] = $urandom();
        d_be[k] = 4'($urandom_range(15));
      end
    end else if ($urandom_range(15) == 0) begin
      d_req[k] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      reset_model(k);
      clr_log(k);
      resp_f[k] = 1'b0; resp_st[k] = 1'b0; resp_data[k] = '0; mret_addr[k] = '0;
      m_fg[k] = 1'b0; m_dg[k] = 1'b0;
    end
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();

    // Single fetch, MEM_LAT=1
    clr_log(0);
    if_req[0] = 1'b1; if_addr[0] = 32'h10; t0 = cyc_n;
    repeat (4) cyc();
    chk("t1_fgnt_cycle", 0, fg_c[0] - t0, 0);
    chk("t1_fgnt_addr",  0, fg_addr[0], 32'h10);
    chk("t1_fgnt_we",    0, 32'(fg_we[0]), 0);
    chk("t1_frv_cycle",  0, frv_c[0] - t0, 2);
    chk("t1_frdata",     0, frv_data[0], 32'h00A00093);
    chk("t1_busy_cycles", 0, busy_n[0], 1);

    // Simultaneous fetch + load
    clr_log(0);
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h100; t0 = cyc_n;
    repeat (6) cyc();
    chk("t2_dgnt_cycle", 0, dg_c[0] - t0, 0);
    chk("t2_drv_cycle",  0, drv_c[0] - t0, 2);
    chk("t2_fgnt_cycle", 0, fg_c[0] - t0, 2);
    chk("t2_frv_cycle",  0, frv_c[0] - t0, 4);
    chk("t2_d_rdata",    0, d_rdata[0], memf(32'h100));

    // Store leaves d_rdata alone
    clr_log(0);
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h200;
    d_wdata[0] = 32'hDEADBEEF; d_be[0] = 4'b0011; t0 = cyc_n;
    repeat (4) cyc();
    chk("t3_dgnt_cycle", 0, dg_c[0] - t0, 0);
    chk("t3_mem_we",     0, 32'(st_we[0]), 1);
    chk("t3_mem_be",     0, 32'(st_be[0]), 32'h3);
    chk("t3_mem_wdata",  0, st_wd[0], 32'hDEADBEEF);
    chk("t3_drv_cycle",  0, drv_c[0] - t0, 2);
    chk("t3_d_rdata",    0, d_rdata[0], memf(32'h100));

    // Starvation guard with both requests held
    clr_log(0);
    d_we[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if_req[0] = 1'b1; if_addr[0] = 32'h1000 + 32'(i * 4);
      d_req[0] = 1'b1;  d_addr[0] = 32'h2000 + 32'(i * 4);
      cyc();
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (2) cyc();
    chk_s("t4_grant_order", order[0], "DDDDFDDDDF");

    // MEM_LAT=3 fetch then pending load
    clr_log(1);
    if_req[1] = 1'b1; if_addr[1] = 32'h300; t0 = cyc_n;
    cyc();
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h304;
    repeat (9) cyc();
    chk("t5_fgnt_cycle", 1, fg_c[1] - t0, 0);
    chk("t5_frv_cycle",  1, frv_c[1] - t0, 4);
    chk("t5_frdata",     1, frv_data[1], memf(32'h300));
    chk("t5_dgnt_cycle", 1, dg_c[1] - t0, 4);
    chk("t5_drv_cycle",  1, drv_c[1] - t0, 8);

    // Reset in the middle of a MEM_LAT=3 fetch
    clr_log(1);
    if_req[1] = 1'b1; if_addr[1] = 32'h380; t0 = cyc_n;
    cyc();
    if_req[1] = 1'b1;
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (6) cyc();
    chk("t6_regrant_cycle", 1, fg_c[1] - t0, 3);
    chk("t6_first_frv",     1, frv_c[1] - t0, 7);
    chk("t6_if_rdata",      1, if_rdata[1], memf(32'h380));

    // Random traffic on both instances
    repeat (400) begin
      rnd(0);
      rnd(1);
      cyc();
    end
    if_req = '0; d_req = '0;
    repeat (6) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
